bus_arbiter_mux_n: RTL and testbench

Registered N-channel bus multiplexer with valid/ready handshakes on every input and on the output. It is the clocked successor to the team's 4-to-1 combinational bus mux. It generalises the fixed four inputs to NUM_CH channels and adds three selection modes: round-robin, fixed priority, and manual SEL. It sits between several bus producers and one shared downstream consumer, with one register stage of latency.

---
 rtl/bus_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/bus_arbiter_mux_n.sv | 81 ++++++++
 tb/tb_bus_arbiter_mux_n.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bus_mux_pkg.sv
// Shared definitions for the N-channel registered bus multiplexer.
// Mode encodings used by both the arbiter and the top level.
package bus_mux_pkg;

  typedef enum logic [1:0] {
    MODE_RR     = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_MANUAL = 2'b10,
    MODE_RR_ALT = 2'b11
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: round-robin from LAST+1, or lowest-index first.
// Manual selection arrives already masked to a single request, so it shares the priority path.
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_last,
  input  logic [1:0]        i_mode,
  output logic [NUM_CH-1:0] o_grant,
  output logic [SEL_W-1:0]  o_idx
);

  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_fix_idx;
  logic [SEL_W-1:0] w_cand;

  // Scan from lowest to highest priority so the last hit wins; no per-step control flow.
  always_comb begin
    w_rr_idx  = '0;
    w_fix_idx = '0;
    w_cand    = '0;
    o_idx     = '0;
    o_grant   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_cand   = SEL_W'((int'(i_last) + k) % NUM_CH);
      w_rr_idx = i_req[w_cand] ? w_cand : w_rr_idx;
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_fix_idx = i_req[i] ? SEL_W'(i) : w_fix_idx;
    end
    case (i_mode)
      MODE_FIXED, MODE_MANUAL: o_idx = w_fix_idx;
      default:                 o_idx = w_rr_idx;
    endcase
    o_grant = (|i_req) ? (NUM_CH'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/bus_arbiter_mux_n.sv
// Registered N-channel bus multiplexer with valid/ready on every input and on the output.
// One register stage; LAST tracks the most recently served channel in every mode.
module bus_arbiter_mux_n
  import bus_mux_pkg::*;
#(
  parameter  int BUS_WIDTH = 8,
  parameter  int NUM_CH    = 4,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CH*BUS_WIDTH-1:0] i_in_data,
  input  logic [NUM_CH-1:0]           i_in_valid,
  output logic [NUM_CH-1:0]           o_in_ready,
  input  logic [1:0]                  i_mode,
  input  logic [SEL_W-1:0]            i_sel,
  output logic [BUS_WIDTH-1:0]        o_y,
  output logic                        o_y_valid,
  input  logic                        i_y_ready,
  output logic [SEL_W-1:0]            o_y_ch
);

  logic [BUS_WIDTH-1:0] r_y;
  logic                 r_y_valid;
  logic [SEL_W-1:0]     r_y_ch;
  logic [SEL_W-1:0]     r_last;

  logic                 w_load_en;
  logic [NUM_CH-1:0]    w_req;
  logic [NUM_CH-1:0]    w_grant;
  logic [SEL_W-1:0]     w_idx;
  logic [NUM_CH-1:0]    w_in_ready;
  logic                 w_xfer;

  assign w_load_en = !r_y_valid || i_y_ready;

  // Manual mode narrows the request vector to SEL; out-of-range SEL requests nothing.
  always_comb begin
    w_req = i_in_valid;
    case (i_mode)
      MODE_MANUAL: w_req = (int'(i_sel) < NUM_CH) ? (i_in_valid & (NUM_CH'(1) << i_sel)) : '0;
      default:     w_req = i_in_valid;
    endcase
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req   (w_req),
    .i_last  (r_last),
    .i_mode  (i_mode),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_in_ready = (w_load_en && i_rst_n) ? w_grant : '0;
  assign w_xfer     = |w_in_ready;

  // Output register and LAST; an empty grant slot drains Y_VALID but keeps Y and Y_CH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_ch    <= '0;
      r_last    <= SEL_W'(NUM_CH - 1);
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_y       <= i_in_data[int'(w_idx)*BUS_WIDTH +: BUS_WIDTH];
        r_y_ch    <= w_idx;
        r_y_valid <= 1'b1;
        r_last    <= w_idx;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_y        = r_y;
  assign o_y_valid  = r_y_valid;
  assign o_y_ch     = r_y_ch;

endmodule

// File: tb/tb_bus_arbiter_mux_n.sv
// Self-checking bench for bus_arbiter_mux_n: directed plan scenarios plus randomized
// traffic, all compared against a transaction-level model of the mux.
module tb_bus_arbiter_mux_n;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   ch_data [N];
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [1:0]   mode;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;
  logic [1:0]   y_ch;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the output register and last-served channel should hold.
  int m_y, m_yv, m_ych, m_last;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  always #5 clk = ~clk;

  bus_arbiter_mux_n #(.BUS_WIDTH(W), .NUM_CH(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_mode     (mode),
    .i_sel      (sel),
    .o_y        (y),
    .o_y_valid  (y_valid),
    .i_y_ready  (y_ready),
    .o_y_ch     (y_ch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_y = 0; m_yv = 0; m_ych = 0; m_last = N - 1;
  endfunction

  // Which channel should be granted now, or -1 for none.
  function automatic int model_grant();
    int c;
    if (!rst_n) return -1;
    if (m_yv != 0 && !y_ready) return -1;
    if (mode == 2'b01) begin
      for (int i = 0; i < N; i++) if (in_valid[i]) return i;
      return -1;
    end
    if (mode == 2'b10) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input logic [3:0] v, input logic [1:0] md, input logic [1:0] s, input logic yr);
    int g;
    logic [3:0] exp_rdy;
    in_valid = v; mode = md; sel = s; y_ready = yr;
    #2;
    g = model_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst_n && (m_yv == 0 || yr)) begin
      if (g >= 0) begin
        m_y = int'(ch_data[g]); m_ych = g; m_yv = 1; m_last = g;
      end else begin
        m_yv = 0;
      end
    end
    #1;
    check("y_valid", 32'(y_valid), 32'(m_yv));
    check("y_ch", 32'(y_ch), 32'(m_ych));
    check("y", 32'(y), 32'(m_y));
  endtask

  task automatic set_plan_data();
    ch_data[0] = 8'h18; ch_data[1] = 8'hD8; ch_data[2] = 8'h00; ch_data[3] = 8'h1B;
  endtask

  initial begin
    logic [7:0] rr_y [5];
    int         rr_c [5];
    rr_y[0] = 8'h18; rr_y[1] = 8'hD8; rr_y[2] = 8'h00; rr_y[3] = 8'h1B; rr_y[4] = 8'h18;
    rr_c[0] = 0; rr_c[1] = 1; rr_c[2] = 2; rr_c[3] = 3; rr_c[4] = 0;

    set_plan_data();
    rst_n = 1'b0; in_valid = 4'b1111; mode = 2'b00; sel = 2'd0; y_ready = 1'b1;
    model_reset();
    #12;
    check("rst_y", 32'(y), 32'h0);
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_y_ch", 32'(y_ch), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 2'b00, 2'd0, 1'b1);
      check("rr_seq_y", 32'(y), 32'(rr_y[i]));
      check("rr_seq_ch", 32'(y_ch), 32'(rr_c[i]));
    end

    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 2'b00, 2'd0, 1'b0);
      check("bp_y", 32'(y), 32'h18);
      check("bp_ch", 32'(y_ch), 32'h0);
    end
    step(4'b1111, 2'b00, 2'd0, 1'b1);
    check("bp_resume_ch", 32'(y_ch), 32'h1);

    for (int i = 0; i < 4; i++) begin
      step(4'b0110, 2'b01, 2'd0, 1'b1);
      check("fix_y", 32'(y), 32'hD8);
      check("fix_ch", 32'(y_ch), 32'h1);
    end

    step(4'b1111, 2'b10, 2'd3, 1'b1);
    check("man_y", 32'(y), 32'h1B);
    check("man_ch", 32'(y_ch), 32'h3);
    step(4'b1011, 2'b10, 2'd2, 1'b1);
    check("man_nogrant_valid", 32'(y_valid), 32'h0);

    step(4'b1111, 2'b00, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_y_valid", 32'(y_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step(4'b1111, 2'b00, 2'd0, 1'b1);
    check("midrst_first_y", 32'(y), 32'h18);
    check("midrst_first_ch", 32'(y_ch), 32'h0);

    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) ch_data[c] = 8'($urandom);
      step(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
